// File: rtl/line_draw_pkg.sv
// Shared definitions for the line-drawing pixel path: default geometry,
// coordinate widths, writer FSM encoding and point FIFO entry sizing.
package line_draw_pkg;

  localparam int unsigned X_COORD_W  = 11;
  localparam int unsigned Y_COORD_W  = 11;
  localparam int unsigned FB_WIDTH   = 640;
  localparam int unsigned FB_HEIGHT  = 480;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned COLOR_W    = 8;
  localparam int unsigned FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // FIFO entry is packed MSB-first as {x, y, color, line_end}.
  function automatic int unsigned entry_width(input int unsigned xw,
                                              input int unsigned yw,
                                              input int unsigned cw);
    return xw + yw + cw + 1;
  endfunction

endpackage

// File: rtl/line_point_fifo.sv
// Parameterized synchronous FIFO with combinational head read.
// DEPTH must be a power of two, at least 2; pointers carry an extra wrap bit.
module line_point_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/line_pixel_writer.sv
// Retires Bresenham points into the framebuffer port: FIFO, clip, address, write.
// LINE_PIXEL_WRITER_STATS_EN adds saturating write/clip counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nothing held; pops FIFO head as soon as one is present
//   ST_FETCH | held point evaluated: clip check, address/data registered
//   ST_WRITE | o_fb_we high, address/data frozen until i_fb_ack
module line_pixel_writer
  import line_draw_pkg::*;
#(
  parameter int unsigned P_X_COORD_W  = X_COORD_W,
  parameter int unsigned P_Y_COORD_W  = Y_COORD_W,
  parameter int unsigned P_FB_WIDTH   = FB_WIDTH,
  parameter int unsigned P_FB_HEIGHT  = FB_HEIGHT,
  parameter int unsigned P_ADDR_W     = ADDR_W,
  parameter int unsigned P_COLOR_W    = COLOR_W,
  parameter int unsigned P_FIFO_DEPTH = FIFO_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [P_X_COORD_W-1:0] i_x_val,
  input  logic [P_Y_COORD_W-1:0] i_y_val,
  input  logic [P_COLOR_W-1:0]   i_color,
  input  logic                   i_pix_valid,
  input  logic                   i_line_end,
  output logic                   o_pix_ready,
  output logic [P_ADDR_W-1:0]    o_fb_addr,
  output logic [P_COLOR_W-1:0]   o_fb_data,
  output logic                   o_fb_we,
  input  logic                   i_fb_ack,
  output logic                   o_line_done,
`ifdef LINE_PIXEL_WRITER_STATS_EN
  output logic                   o_waiting,
  output logic [31:0]            o_wr_count,
  output logic [31:0]            o_clip_count
`else
  output logic                   o_waiting
`endif
);

  localparam int unsigned ENTRY_W = entry_width(P_X_COORD_W, P_Y_COORD_W, P_COLOR_W);

  state_t                 state, next_state;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop;
  logic [ENTRY_W-1:0]     push_entry, head;
  logic [P_X_COORD_W-1:0] hold_x;
  logic [P_Y_COORD_W-1:0] hold_y;
  logic [P_COLOR_W-1:0]   hold_color;
  logic                   hold_le;
  logic                   clip;
  logic [P_ADDR_W-1:0]    lin_addr;

  assign push       = i_pix_valid && !fifo_full;
  assign push_entry = {i_x_val, i_y_val, i_color, i_line_end};

  line_point_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .reset   (i_reset),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_pix_ready = !fifo_full;
  assign o_fb_we     = (state == ST_WRITE);
  assign o_waiting   = (state == ST_IDLE) && fifo_empty;

  assign clip     = (32'(hold_x) >= P_FB_WIDTH) || (32'(hold_y) >= P_FB_HEIGHT);
  assign lin_addr = P_ADDR_W'(32'(hold_y) * P_FB_WIDTH + 32'(hold_x));

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: next_state = clip ? ST_IDLE : ST_WRITE;
      ST_WRITE: begin
        // Chain straight into the next point so back-to-back writes take 2 cycles.
        if (i_fb_ack) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      hold_x      <= '0;
      hold_y      <= '0;
      hold_color  <= '0;
      hold_le     <= 1'b0;
      o_fb_addr   <= '0;
      o_fb_data   <= '0;
      o_line_done <= 1'b0;
    end else begin
      state       <= next_state;
      o_line_done <= 1'b0;
      if (pop) {hold_x, hold_y, hold_color, hold_le} <= head;
      if (state == ST_FETCH) begin
        if (clip) begin
          o_line_done <= hold_le;
        end else begin
          o_fb_addr <= lin_addr;
          o_fb_data <= hold_color;
        end
      end
      if (state == ST_WRITE && i_fb_ack) o_line_done <= hold_le;
    end
  end

`ifdef LINE_PIXEL_WRITER_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wr_count   <= '0;
      o_clip_count <= '0;
    end else begin
      if (state == ST_WRITE && i_fb_ack && o_wr_count != '1)
        o_wr_count <= o_wr_count + 1'b1;
      if (state == ST_FETCH && clip && o_clip_count != '1)
        o_clip_count <= o_clip_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_line_pixel_writer.sv
// Randomized bench for line_pixel_writer against an ordered event-queue model
// of writes and line_done pulses derived from the accepted point stream.
module tb_line_pixel_writer;

  localparam int unsigned FB_W = 640;
  localparam int unsigned FB_H = 480;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [10:0] i_x_val, i_y_val;
  logic [7:0]  i_color;
  logic        i_pix_valid, i_line_end;
  logic        o_pix_ready;
  logic [18:0] o_fb_addr;
  logic [7:0]  o_fb_data;
  logic        o_fb_we;
  logic        i_fb_ack;
  logic        o_line_done;
  logic        o_waiting;
`ifdef LINE_PIXEL_WRITER_STATS_EN
  logic [31:0] o_wr_count, o_clip_count;
`endif

  always #5 i_clk = ~i_clk;

  line_pixel_writer dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_x_val     (i_x_val),
    .i_y_val     (i_y_val),
    .i_color     (i_color),
    .i_pix_valid (i_pix_valid),
    .i_line_end  (i_line_end),
    .o_pix_ready (o_pix_ready),
    .o_fb_addr   (o_fb_addr),
    .o_fb_data   (o_fb_data),
    .o_fb_we     (o_fb_we),
    .i_fb_ack    (i_fb_ack),
    .o_line_done (o_line_done),
`ifdef LINE_PIXEL_WRITER_STATS_EN
    .o_waiting   (o_waiting),
    .o_wr_count  (o_wr_count),
    .o_clip_count(o_clip_count)
`else
    .o_waiting   (o_waiting)
`endif
  );

  typedef struct {
    bit          done;
    logic [18:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0, n_err = 0;
  int          ack_mode, ack_delay, we_cycles;
  bit          hold_pending, accepted, chk_depth, saw_full;
  logic [18:0] prev_addr;
  logic [7:0]  prev_data;
  int          wr_seen, done_seen, push_cnt, clip_exp, wr_exp;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: each accepted point yields an on-screen write, then a done if it ends a line.
  task automatic model_push(input logic [10:0] x, input logic [10:0] y,
                            input logic [7:0] c, input logic le);
    ev_t e;
    if (int'(x) < int'(FB_W) && int'(y) < int'(FB_H)) begin
      e.done = 1'b0;
      e.addr = 19'((int'(y) * int'(FB_W) + int'(x)) % (1 << 19));
      e.data = c;
      exp_q.push_back(e);
      wr_exp++;
    end else begin
      clip_exp++;
    end
    if (le) begin
      e.done = 1'b1;
      e.addr = '0;
      e.data = '0;
      exp_q.push_back(e);
    end
  endtask

  // Called at a falling edge: drive inputs, check what the next rising edge retires.
  task automatic drive(input logic v, input logic [10:0] x, input logic [10:0] y,
                       input logic [7:0] c, input logic le);
    logic ack;
    case (ack_mode)
      0:       ack = o_fb_we && (we_cycles >= ack_delay);
      1:       ack = 1'($urandom_range(0, 1));
      default: ack = 1'b0;
    endcase
    i_pix_valid = v;
    i_x_val     = x;
    i_y_val     = y;
    i_color     = c;
    i_line_end  = le;
    i_fb_ack    = ack;

    if (o_line_done) begin
      done_seen++;
      if (exp_q.size() > 0) begin
        chk_val("line_done_order", o_line_done, exp_q[0].done);
        if (exp_q[0].done) exp_q.delete(0);
      end else begin
        chk_val("line_done_unexpected", o_line_done, 1'b0);
      end
    end
    if (hold_pending)
      chk_val("hold_stable", {o_fb_we, o_fb_addr, o_fb_data}, {1'b1, prev_addr, prev_data});
    if (o_fb_we && ack) begin
      wr_seen++;
      if (exp_q.size() > 0) begin
        chk_val("wr_order", o_fb_we, !exp_q[0].done);
        if (!exp_q[0].done) begin
          chk_val("wr_addr", o_fb_addr, exp_q[0].addr);
          chk_val("wr_data", o_fb_data, exp_q[0].data);
          exp_q.delete(0);
        end
      end else begin
        chk_val("wr_unexpected", o_fb_we, 1'b0);
      end
    end
    if (chk_depth && !o_pix_ready && !saw_full) begin
      saw_full = 1'b1;
      chk_val("full_depth", push_cnt - wr_seen, 9);
    end

    if (o_fb_we && !ack) begin
      hold_pending = 1'b1;
      prev_addr    = o_fb_addr;
      prev_data    = o_fb_data;
      we_cycles++;
    end else begin
      hold_pending = 1'b0;
      we_cycles    = 0;
    end

    accepted = v && o_pix_ready;
    if (accepted) begin
      push_cnt++;
      model_push(x, y, c, le);
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic push_point(input logic [10:0] x, input logic [10:0] y,
                            input logic [7:0] c, input logic le);
    int t = 0;
    accepted = 1'b0;
    while (!accepted && t < 200) begin
      drive(1'b1, x, y, c, le);
      t++;
    end
    if (!accepted) chk_val("push_timeout", accepted, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    ack_mode  = 0;
    ack_delay = 0;
    while ((exp_q.size() > 0 || !o_waiting) && t < 3000) begin
      idle(1);
      t++;
    end
    chk_val("drain_queue", exp_q.size(), 0);
    idle(3);
    chk_val("drain_waiting", o_waiting, 1'b1);
  endtask

  task automatic apply_reset();
    i_reset     = 1'b1;
    i_pix_valid = 1'b0;
    i_fb_ack    = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0;
    we_cycles    = 0;
    wr_seen      = 0;
    done_seen    = 0;
    push_cnt     = 0;
    clip_exp     = 0;
    wr_exp       = 0;
    chk_depth    = 1'b0;
    saw_full     = 1'b0;
  endtask

  initial begin
    int lat;
    i_reset = 1'b1; i_pix_valid = 1'b0; i_line_end = 1'b0; i_fb_ack = 1'b0;
    i_x_val = '0; i_y_val = '0; i_color = '0;
    ack_mode = 0; ack_delay = 0;
    apply_reset();

    chk_val("rst_we", o_fb_we, 1'b0);
    chk_val("rst_line_done", o_line_done, 1'b0);
    chk_val("rst_addr", o_fb_addr, 19'd0);
    chk_val("rst_data", o_fb_data, 8'd0);
    chk_val("rst_ready", o_pix_ready, 1'b1);
    chk_val("rst_waiting", o_waiting, 1'b1);

    // Single point, zero-wait ack
    drive(1'b1, 11'd5, 11'd5, 8'hA5, 1'b1);
    chk_val("single_accept", accepted, 1'b1);
    lat = 1;
    while (!o_fb_we && lat < 10) begin
      idle(1);
      lat++;
    end
    chk_val("single_latency", lat, 3);
    chk_val("single_addr", o_fb_addr, 19'd3205);
    chk_val("single_busy", o_waiting, 1'b0);
    drain();
    chk_val("single_writes", wr_seen, 1);
    chk_val("single_done", done_seen, 1);

    // Line burst with 3-cycle ack delay
    apply_reset();
    ack_mode = 0; ack_delay = 3; chk_depth = 1'b1;
    for (int i = 0; i <= 10; i++) push_point(11'(i), 11'd0, 8'(i + 1), i == 10);
    chk_val("burst_full_seen", saw_full, 1'b1);
    chk_depth = 1'b0;
    drain();
    chk_val("burst_writes", wr_seen, 11);
    chk_val("burst_done", done_seen, 1);

    // Clipping in x and y
    apply_reset();
    push_point(11'd700, 11'd10, 8'h11, 1'b0);
    push_point(11'd3, 11'd480, 8'h22, 1'b0);
    push_point(11'd3, 11'd8, 8'h33, 1'b1);
    drain();
    chk_val("clip_writes", wr_seen, 1);
    chk_val("clip_done", done_seen, 1);
`ifdef LINE_PIXEL_WRITER_STATS_EN
    chk_val("clip_stat_clip", o_clip_count, 2);
    chk_val("clip_stat_wr", o_wr_count, 1);
`endif

    // Clipped last point still ends the line
    apply_reset();
    push_point(11'd10, 11'd10, 8'h44, 1'b0);
    push_point(11'd640, 11'd0, 8'h55, 1'b1);
    drain();
    chk_val("cliplast_writes", wr_seen, 1);
    chk_val("cliplast_done", done_seen, 1);

    // Backpressure: no ack, valid held high
    apply_reset();
    ack_mode = 2; chk_depth = 1'b1;
    repeat (25) drive(1'b1, 11'($urandom_range(0, 639)), 11'($urandom_range(0, 479)),
                      8'($urandom), 1'b0);
    chk_val("bp_accepted", push_cnt, 9);
    chk_val("bp_ready", o_pix_ready, 1'b0);
    chk_val("bp_we", o_fb_we, 1'b1);
    chk_depth = 1'b0;
    drain();
    chk_val("bp_writes", wr_seen, 9);

    // Reset while a write is pending with 4 queued
    apply_reset();
    ack_mode = 2;
    for (int i = 0; i < 5; i++) push_point(11'(20 + i), 11'd1, 8'(i), i == 4);
    lat = 0;
    while (!o_fb_we && lat < 20) begin
      idle(1);
      lat++;
    end
    chk_val("mid_we_before", o_fb_we, 1'b1);
    i_reset = 1'b1; i_pix_valid = 1'b0; i_fb_ack = 1'b0;
    @(negedge i_clk);
    chk_val("mid_we_after", o_fb_we, 1'b0);
    chk_val("mid_ready_after", o_pix_ready, 1'b1);
    chk_val("mid_done_after", o_line_done, 1'b0);
    chk_val("mid_waiting_after", o_waiting, 1'b1);
    i_reset = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0; we_cycles = 0; wr_seen = 0; done_seen = 0;
    ack_mode = 1;
    idle(20);
    chk_val("mid_no_writes", wr_seen, 0);
    chk_val("mid_no_done", done_seen, 0);

    // Random traffic with random acks
    apply_reset();
    ack_mode = 1;
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 11'($urandom_range(0, 700)), 11'($urandom_range(0, 520)),
            8'($urandom), $urandom_range(0, 3) == 0);
    drain();
    chk_val("rand_writes", wr_seen, wr_exp);
`ifdef LINE_PIXEL_WRITER_STATS_EN
    chk_val("rand_stat_wr", o_wr_count, wr_exp);
    chk_val("rand_stat_clip", o_clip_count, clip_exp);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
